result_serializer: RTL

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/systolic_pkg.sv | 15 +
 rtl/result_serializer_if.sv | 36 +++
 rtl/result_frame_buf.sv | 40 ++++
 rtl/result_serializer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared widths, dimension bounds and serializer states
// for the systolic array result path.
package systolic_pkg;

  localparam int RESULT_W  = 32;
  localparam int OPERAND_W = 8;
  localparam int N_MIN     = 3;
  localparam int N_MAX     = 256;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/result_serializer_if.sv
// Element stream from the result serializer to its sink:
// valid/ready handshake with row/col tags and a last marker.
interface result_serializer_if
  import systolic_pkg::*;
#(
  parameter int N = 4
);

  localparam int IDX_W = $clog2(N);

  logic [RESULT_W-1:0] o_data;
  logic [IDX_W-1:0]    o_row;
  logic [IDX_W-1:0]    o_col;
  logic                o_valid;
  logic                o_last;
  logic                i_ready;

  modport master (
    output o_data,
    output o_row,
    output o_col,
    output o_valid,
    output o_last,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_row,
    input  o_col,
    input  o_valid,
    input  o_last,
    output i_ready
  );

endinterface

// File: rtl/result_frame_buf.sv
// One N x N result frame: whole-frame load, optional
// row/col element read port.
module result_frame_buf
  import systolic_pkg::*;
#(
  parameter  bit HAS_MUX = 1'b1,
  parameter  int N       = 4,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_load,
  input  logic [RESULT_W-1:0] i_d [N][N],
  input  logic [IDX_W-1:0]    i_row,
  input  logic [IDX_W-1:0]    i_col,
  output logic [RESULT_W-1:0] o_q [N][N],
  output logic [RESULT_W-1:0] o_rd
);

  logic [RESULT_W-1:0] mem [N][N];

  // Payload only; validity is tracked by the owner.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      mem <= i_d;
    end
  end

  assign o_q = mem;

  generate
    if (HAS_MUX) begin : g_mux
      assign o_rd = mem[i_row][i_col];
    end else begin : g_no_mux
      logic unused_idx;
      assign unused_idx = ^{i_row, i_col};
      assign o_rd       = '0;
    end
  endgenerate

endmodule

// File: rtl/result_serializer.sv
// Streams N x N result frames row-major over a valid/ready
// port, with a one-deep frame backlog and sticky overrun.
module result_serializer
  import systolic_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                i_clk,
  input  logic                i_arst_n,
  input  logic [RESULT_W-1:0] i_c [N][N],
  input  logic                i_validResult,
  result_serializer_if.master res_if,
  output logic                o_busy,
  output logic                o_overrun,
  input  logic                i_clearOverrun
);

  generate
    if (N < N_MIN || N > N_MAX) begin : g_bad_n
      $error("result_serializer: N=%0d out of range", N);
    end
  endgenerate

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  ser_state_e       state;
  logic             pend_valid;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] col;
  logic             overrun;

  logic streaming;
  logic at_last;
  logic xfer;
  logic last_xfer;
  logic load_act;
  logic act_from_pend;
  logic load_pend;
  logic drop;

  logic [RESULT_W-1:0] act_d [N][N];
  logic [RESULT_W-1:0] pend_q [N][N];
  logic [RESULT_W-1:0] unused_act_q [N][N];
  logic [RESULT_W-1:0] act_rd;
  logic [RESULT_W-1:0] unused_pend_rd;

  assign streaming = (state == ST_STREAM);
  assign at_last   = (row == LAST_IDX) && (col == LAST_IDX);
  assign xfer      = streaming & res_if.i_ready;
  assign last_xfer = xfer & at_last;

  // A frame finishing this cycle frees a slot, so an
  // arriving frame is never dropped on the last beat.
  always_comb begin
    load_act      = 1'b0;
    act_from_pend = 1'b0;
    load_pend     = 1'b0;
    drop          = 1'b0;
    unique case (1'b1)
      !streaming: begin
        load_act = i_validResult;
      end
      last_xfer: begin
        load_act      = pend_valid | i_validResult;
        act_from_pend = pend_valid;
        load_pend     = pend_valid & i_validResult;
      end
      default: begin
        load_pend = i_validResult & ~pend_valid;
        drop      = i_validResult & pend_valid;
      end
    endcase
  end

  always_comb begin
    if (act_from_pend) begin
      act_d = pend_q;
    end else begin
      act_d = i_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      row        <= '0;
      col        <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load_act) begin
        state <= ST_STREAM;
        row   <= '0;
        col   <= '0;
      end else if (last_xfer) begin
        state <= ST_IDLE;
        row   <= '0;
        col   <= '0;
      end else if (xfer) begin
        if (col == LAST_IDX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (load_pend) begin
        pend_valid <= 1'b1;
      end else if (last_xfer) begin
        pend_valid <= 1'b0;
      end

      // Setting wins over a same-cycle clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (i_clearOverrun) begin
        overrun <= 1'b0;
      end
    end
  end

  result_frame_buf #(
    .HAS_MUX (1'b1),
    .N       (N)
  ) u_active (
    .i_clk  (i_clk),
    .i_load (load_act),
    .i_d    (act_d),
    .i_row  (row),
    .i_col  (col),
    .o_q    (unused_act_q),
    .o_rd   (act_rd)
  );

  result_frame_buf #(
    .HAS_MUX (1'b0),
    .N       (N)
  ) u_pending (
    .i_clk  (i_clk),
    .i_load (load_pend),
    .i_d    (i_c),
    .i_row  (row),
    .i_col  (col),
    .o_q    (pend_q),
    .o_rd   (unused_pend_rd)
  );

  assign res_if.o_valid = streaming;
  assign res_if.o_row   = row;
  assign res_if.o_col   = col;
  assign res_if.o_last  = streaming & at_last;
  assign res_if.o_data  = streaming ? act_rd : '0;

  assign o_busy    = streaming | pend_valid;
  assign o_overrun = overrun;

endmodule
